// File: rtl/seven_seg_scanner_pkg.sv
// Shared state encoding and active-high segment glyphs for the seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}.
package seven_seg_scanner_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle: scan strobe and value/dp requests in, pin-level anode/segment/dp out.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      scanClk;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dpIn;
    logic                      blankLead;
    logic [NUM_DIGITS-1:0]     anodes;
    logic [6:0]                segments;
    logic                      dp;

    modport master (
        output scanClk, value, dpIn, blankLead,
        input  anodes, segments, dp
    );

    modport slave (
        input  scanClk, value, dpIn, blankLead,
        output anodes, segments, dp
    );
endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver with dead-time between digits and
// per-frame snapshot of the displayed value.
//
//   state    | meaning
//   ST_BLANK | all anodes off, counting dead-time before lighting digit_idx
//   ST_DRIVE | digit_idx lit from the snapshot until the next scan strobe edge
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DEAD_CYCLES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
)(
    input  logic clkIn,
    input  logic reset,
    seven_seg_scanner_if.slave bus
);

    localparam int                    IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            DEAD_LAST = 8'(DEAD_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_PIN_OFF = {7{ACTIVE_LOW}};

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [7:0]              dead_q;
    logic                    scan_q;
    logic                    first_q;
    logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]   anodes_q;
    logic [6:0]              segments_q;
    logic                    dp_q;

    logic                    tick;
    logic                    wrap;
    logic                    capture;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic                    zero_above;
    logic                    blank_digit;
    logic [NUM_DIGITS-1:0]   an_on;
    logic [6:0]              seg_on;
    logic                    dp_on;

    assign tick    = bus.scanClk & ~scan_q;
    assign wrap    = (state_q == ST_DRIVE) && tick && (idx_q == LAST_IDX);
    assign capture = first_q | wrap;

    assign snap_val_d   = capture ? bus.value     : snap_val_q;
    assign snap_dp_d    = capture ? bus.dpIn      : snap_dp_q;
    assign snap_blank_d = capture ? bus.blankLead : snap_blank_q;

    // Decode from the next snapshot so a capture and DRIVE entry on the same edge agree.
    assign nibble = snap_val_d[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    always_comb begin
        zero_above = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && snap_val_d[i*4 +: 4] != 4'h0) begin
                zero_above = 1'b0;
            end
        end
    end

    assign blank_digit = snap_blank_d && (idx_q != '0) && zero_above;
    assign an_on       = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
    assign seg_on      = (blank_digit ? SEG_OFF : glyph) ^ SEG_PIN_OFF;
    assign dp_on       = snap_dp_d[idx_q] ^ ACTIVE_LOW;

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            dead_q       <= 8'd0;
            scan_q       <= 1'b0;
            first_q      <= 1'b1;
            snap_val_q   <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= 1'b0;
            anodes_q     <= AN_OFF;
            segments_q   <= SEG_PIN_OFF;
            dp_q         <= ACTIVE_LOW;
        end else begin
            scan_q       <= bus.scanClk;
            first_q      <= 1'b0;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            if (state_q == ST_BLANK) begin
                if (dead_q == DEAD_LAST) begin
                    dead_q     <= 8'd0;
                    state_q    <= ST_DRIVE;
                    anodes_q   <= an_on;
                    segments_q <= seg_on;
                    dp_q       <= dp_on;
                end else begin
                    dead_q <= dead_q + 8'd1;
                end
            end else if (tick) begin
                state_q    <= ST_BLANK;
                idx_q      <= wrap ? '0 : idx_q + 1'b1;
                anodes_q   <= AN_OFF;
                segments_q <= SEG_PIN_OFF;
                dp_q       <= ACTIVE_LOW;
            end
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.segments = segments_q;
    assign bus.dp       = dp_q;

endmodule
